// File: rtl/rwmem_lat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mytypes (package)
// Purpose  : Shared types and constants for the rwmem_lat latency memory.
//            - state_t : IDLE / WAIT / DONE request-sequencing states
//            - CNT_W   : width of the DELAY wait counter (DELAY range 0..15)
// Revision : 1.0 - initial release
// ============================================================================
package mytypes;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rwmem_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : rwmem_lat_cnt
// Purpose  : Loadable down-counter with zero flag. Used to time the wait
//            phase of an accepted memory request.
// Ports    : clk_i       - clock, rising edge
//            rst_ni      - synchronous active-low reset (count -> 0)
//            load_i      - load load_val_i (has priority over dec_i)
//            load_val_i  - value to load
//            dec_i       - decrement by one, saturating at zero
//            zero_o      - count is zero
//            last_o      - count is one (the next decrement reaches zero)
// Revision : 1.0 - initial release
// ============================================================================
module rwmem_lat_cnt
  import mytypes::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/rwmem_lat.sv
`default_nettype none
// ============================================================================
// Module   : rwmem_lat
// Purpose  : Single-port word memory with a fixed, parameterised access
//            latency. A request is accepted when ENABLE=1 and BUSY=0; the
//            access completes with a one-cycle DATA_READY pulse. Misaligned
//            or out-of-range addresses complete with ERR and no array write.
// Ports    : CLK          - clock, rising edge
//            RST          - synchronous active-low reset
//            ENABLE       - request strobe
//            READNOTWRITE - 1 = read, 0 = write
//            ADDR         - byte address
//            BE           - per-byte write enables
//            DATA_IN      - write data
//            BUSY         - request pending, new requests ignored
//            DATA_READY   - one-cycle completion pulse
//            DATA_OUT     - read data (held until next read/fault completion)
//            ERR          - fault pulse, coincident with DATA_READY
// Revision : 1.0 - initial release
// ============================================================================
module rwmem_lat
  import mytypes::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    DELAY     = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENABLE,
  input  logic                READNOTWRITE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [DATA_W-1:0]   DATA_IN,
  output logic                BUSY,
  output logic                DATA_READY,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic                ERR
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t state_q, state_d;

  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTES-1:0]  be_q;
  logic [DATA_W-1:0] din_q;

  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] dout_q;

  logic cnt_load, cnt_dec, cnt_zero, cnt_last;

  logic accept;
  assign BUSY   = (state_q == WAIT);
  assign accept = ENABLE && !BUSY;

  rwmem_lat_cnt u_cnt (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(DELAY)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero),
    .last_o     (cnt_last)
  );

  // DONE is entered on the edge DELAY cycles after accept, so DATA_READY is
  // visible during the (DELAY+1)-th cycle after the accept edge. The WAIT
  // exit fires on the decrement that takes the counter to zero.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (DELAY == 0) begin
            state_d = DONE;
          end else begin
            state_d  = WAIT;
            cnt_load = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entering DONE from WAIT uses the captured request; entering it straight
  // from an accept (DELAY=0) uses the live inputs being captured that edge.
  logic              req_rnw;
  logic [ADDR_W-1:0] req_addr;
  logic [BYTES-1:0]  req_be;
  logic [DATA_W-1:0] req_din;

  always_comb begin
    if (state_q == WAIT) begin
      req_rnw  = rnw_q;
      req_addr = addr_q;
      req_be   = be_q;
      req_din  = din_q;
    end else begin
      req_rnw  = READNOTWRITE;
      req_addr = ADDR;
      req_be   = BE;
      req_din  = DATA_IN;
    end
  end

  logic             enter_done;
  logic             fault;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;

  assign enter_done = (state_d == DONE);
  assign fault      = ((req_addr & OFF_MASK) != '0) ||
                      ((req_addr >> (OFF_W + IDX_W)) != '0);
  assign idx        = req_addr[OFF_W +: IDX_W];
  assign rd_word    = mem[idx];

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < BYTES; b++) begin
      if (req_be[b]) merged[8*b +: 8] = req_din[8*b +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      din_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rnw_q  <= READNOTWRITE;
        addr_q <= ADDR;
        be_q   <= BE;
        din_q  <= DATA_IN;
      end
      ready_q <= enter_done;
      err_q   <= enter_done && fault;
      if (enter_done && fault) begin
        dout_q <= '0;
      end else if (enter_done && req_rnw) begin
        dout_q <= rd_word;
      end
    end
  end

  // Array contents are deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (RST && enter_done && !req_rnw && !fault) begin
      mem[idx] <= merged;
    end
  end

  assign DATA_READY = ready_q;
  assign ERR        = err_q;
  assign DATA_OUT   = dout_q;

endmodule
`default_nettype wire
